// File: rtl/dm_access.sv
// dm_access: memory-stage load/store access unit.
// Turns the M-stage load/store into one transaction on the microsystem bus and
// freezes the pipeline while that transaction is outstanding. Load data comes
// back byte-selected and sign/zero-extended for the MEM/WB DR input.
//
// Optional feature macro: DM_BUS_TIMEOUT_EN
//   defined   : BUSY gives up after TIMEOUT cycles without bus_ack, pulses bus_err_o
//   undefined : BUSY waits indefinitely, bus_err_o tied 0
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       synchronous active-low reset
//   mem_op_i     M-stage op: 0 none,1 lw,2 lh,3 lhu,4 lb,5 lbu,6 sw,7 sh,8 sb; 9-15 none
//   ao_i         effective address
//   wd_i         store data
//   bus_req_o    transaction request, held until ack
//   bus_we_o     1 = write
//   bus_addr_o   word address ao_i[31:2]
//   bus_be_o     byte enables
//   bus_wdata_o  lane-replicated store data
//   bus_ack_i    transaction complete (1-cycle pulse)
//   bus_rdata_i  read word, valid with bus_ack_i
//   dr_o         extended load data
//   stall_o      pipeline freeze
//   addr_err_o   1-cycle misaligned-access pulse
//   bus_err_o    1-cycle timeout pulse
//
// state | meaning
// IDLE  | no transaction; accepts a new aligned op
// BUSY  | request on the bus, waiting for ack
// DONE  | result ready, pipeline advances; always back to IDLE
module dm_access #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] ao_i,
    input  logic [31:0] wd_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [29:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic [31:0] dr_o,
    output logic        stall_o,
    output logic        addr_err_o,
    output logic        bus_err_o
);

    localparam logic [3:0] OP_LW = 4'd1, OP_LH = 4'd2, OP_LHU = 4'd3, OP_LB = 4'd4,
                           OP_LBU = 4'd5, OP_SW = 4'd6, OP_SH = 4'd7, OP_SB = 4'd8;

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("dm_access: TIMEOUT must be in 2..255");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [29:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  op_q, op_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] dr_q, dr_d;
    logic        aerr_q, aerr_d;
    logic        berr_q, berr_d;

    logic        is_load, is_store, misaligned, go;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic        ld_q;
    logic [15:0] half_sel;
    logic [7:0]  byte_sel;
    logic [31:0] ld_ext;

    assign is_load    = (mem_op_i >= OP_LW) && (mem_op_i <= OP_LBU);
    assign is_store   = (mem_op_i >= OP_SW) && (mem_op_i <= OP_SB);
    assign misaligned = ((mem_op_i == OP_LW || mem_op_i == OP_SW) && (ao_i[1:0] != 2'b00))
                     || ((mem_op_i == OP_LH || mem_op_i == OP_LHU || mem_op_i == OP_SH) && ao_i[0]);
    assign go         = (state_q == IDLE) && (is_load || is_store) && !misaligned;

    always_comb begin
        be_new    = 4'b1111;
        wdata_new = 32'd0;
        case (mem_op_i)
            OP_SW: wdata_new = wd_i;
            OP_SH: begin
                be_new    = ao_i[1] ? 4'b1100 : 4'b0011;
                wdata_new = {2{wd_i[15:0]}};
            end
            OP_SB: begin
                be_new    = 4'b0001 << ao_i[1:0];
                wdata_new = {4{wd_i[7:0]}};
            end
            default: ;
        endcase
    end

    // Extraction works from the latched op/offset, never the live inputs.
    assign ld_q     = (op_q >= OP_LW) && (op_q <= OP_LBU);
    assign half_sel = off_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];

    always_comb begin
        case (off_q)
            2'd0:    byte_sel = bus_rdata_i[7:0];
            2'd1:    byte_sel = bus_rdata_i[15:8];
            2'd2:    byte_sel = bus_rdata_i[23:16];
            default: byte_sel = bus_rdata_i[31:24];
        endcase
    end

    always_comb begin
        case (op_q)
            OP_LH:   ld_ext = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  ld_ext = {16'd0, half_sel};
            OP_LB:   ld_ext = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  ld_ext = {24'd0, byte_sel};
            default: ld_ext = bus_rdata_i;
        endcase
    end

`ifdef DM_BUS_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       expired;
    assign expired = (cnt_q == 8'(TIMEOUT - 1));
`endif

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        op_d    = op_q;
        off_d   = off_q;
        dr_d    = dr_q;
        aerr_d  = 1'b0;
        berr_d  = 1'b0;
`ifdef DM_BUS_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (go) begin
                    state_d = BUSY;
                    we_d    = is_store;
                    addr_d  = ao_i[31:2];
                    be_d    = be_new;
                    wdata_d = wdata_new;
                    op_d    = mem_op_i;
                    off_d   = ao_i[1:0];
`ifdef DM_BUS_TIMEOUT_EN
                    cnt_d   = 8'd0;
`endif
                end else if (is_load || is_store) begin
                    aerr_d = 1'b1;
                end
            end
            BUSY: begin
                if (bus_ack_i) begin
                    if (ld_q) dr_d = ld_ext;
                    state_d = DONE;
`ifdef DM_BUS_TIMEOUT_EN
                end else if (expired) begin
                    berr_d  = 1'b1;
                    if (ld_q) dr_d = 32'd0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= 30'd0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            op_q    <= 4'd0;
            off_q   <= 2'd0;
            dr_q    <= 32'd0;
            aerr_q  <= 1'b0;
            berr_q  <= 1'b0;
`ifdef DM_BUS_TIMEOUT_EN
            cnt_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            op_q    <= op_d;
            off_q   <= off_d;
            dr_q    <= dr_d;
            aerr_q  <= aerr_d;
            berr_q  <= berr_d;
`ifdef DM_BUS_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign bus_req_o   = (state_q == BUSY);
    assign bus_we_o    = we_q;
    assign bus_addr_o  = addr_q;
    assign bus_be_o    = be_q;
    assign bus_wdata_o = wdata_q;
    assign dr_o        = dr_q;
    assign stall_o     = go || (state_q == BUSY);
    assign addr_err_o  = aerr_q;
`ifdef DM_BUS_TIMEOUT_EN
    assign bus_err_o   = berr_q;
`else
    assign bus_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_dm_access.sv
module tb_dm_access;

    localparam int TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [3:0]  mem_op_i;
    logic [31:0] ao_i, wd_i;
    logic        bus_req_o, bus_we_o;
    logic [29:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
    logic [31:0] dr_o;
    logic        stall_o, addr_err_o, bus_err_o;

    dm_access #(.TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .mem_op_i(mem_op_i), .ao_i(ao_i), .wd_i(wd_i),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o), .bus_ack_i(bus_ack_i),
        .bus_rdata_i(bus_rdata_i), .dr_o(dr_o), .stall_o(stall_o),
        .addr_err_o(addr_err_o), .bus_err_o(bus_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic [29:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] dr;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] model_dr = 32'd0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic is_ld(input logic [3:0] op);
        return op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    endfunction

    function automatic exp_t ref_model(input logic [3:0] op, input logic [31:0] ao,
                                       input logic [31:0] wd, input logic [31:0] rd,
                                       input logic [31:0] old_dr);
        exp_t        e;
        logic [31:0] sh;
        e.we = !is_ld(op);
        e.addr = ao[31:2];
        e.be = 4'hF;
        e.wdata = 32'd0;
        e.dr = old_dr;
        sh = rd >> (8 * ao[1:0]);
        case (op)
            4'd1: e.dr = rd;
            4'd2: e.dr = sh[15] ? (sh | 32'hFFFF_0000) : (sh & 32'h0000_FFFF);
            4'd3: e.dr = sh & 32'h0000_FFFF;
            4'd4: e.dr = sh[7] ? (sh | 32'hFFFF_FF00) : (sh & 32'h0000_00FF);
            4'd5: e.dr = sh & 32'h0000_00FF;
            4'd6: e.wdata = wd;
            4'd7: begin
                e.be = ao[1] ? 4'b1100 : 4'b0011;
                e.wdata = (wd[15:0] << 16) | wd[15:0];
            end
            default: begin
                e.be = 4'(1 << ao[1:0]);
                e.wdata = wd[7:0] * 32'h0101_0101;
            end
        endcase
        return e;
    endfunction

    // One full transaction; ack arrives after dly extra BUSY cycles.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] ao,
                          input logic [31:0] wd, input logic [31:0] rd, input int dly);
        exp_t e;
        int   st_cnt;
        @(negedge clk_i);
        mem_op_i = op; ao_i = ao; wd_i = wd;
        sb_q.push_back(ref_model(op, ao, wd, rd, model_dr));
        #1;
        st_cnt = stall_o ? 1 : 0;
        @(negedge clk_i);
        // scramble inputs while BUSY; the latched copy must be used
        mem_op_i = 4'($urandom_range(1, 8)); ao_i = $urandom; wd_i = $urandom;
        e = sb_q.pop_front();
        model_dr = e.dr;
        check_eq({tag, "_req"}, 32'(bus_req_o), 32'd1);
        check_eq({tag, "_we"}, 32'(bus_we_o), 32'(e.we));
        check_eq({tag, "_addr"}, 32'(bus_addr_o), 32'(e.addr));
        check_eq({tag, "_be"}, 32'(bus_be_o), 32'(e.be));
        check_eq({tag, "_wdata"}, bus_wdata_o, e.wdata);
        for (int i = 0; i < dly; i++) begin
            if (stall_o) st_cnt++;
            @(negedge clk_i);
            check_eq({tag, "_hold_addr"}, 32'(bus_addr_o), 32'(e.addr));
            check_eq({tag, "_hold_req"}, 32'(bus_req_o), 32'd1);
        end
        if (stall_o) st_cnt++;
        bus_ack_i = 1'b1; bus_rdata_i = rd;
        @(negedge clk_i);
        bus_ack_i = 1'b0; bus_rdata_i = $urandom; mem_op_i = 4'd0;
        check_eq({tag, "_done_stall"}, 32'(stall_o), 32'd0);
        check_eq({tag, "_done_req"}, 32'(bus_req_o), 32'd0);
        check_eq({tag, "_dr"}, dr_o, e.dr);
        check_eq({tag, "_stall_cycles"}, st_cnt, 2 + dly);
        check_eq({tag, "_bus_err"}, 32'(bus_err_o), 32'd0);
        @(negedge clk_i);
    endtask

    task automatic run_misaligned(input string tag, input logic [3:0] op, input logic [31:0] ao);
        @(negedge clk_i);
        mem_op_i = op; ao_i = ao;
        #1;
        check_eq({tag, "_stall"}, 32'(stall_o), 32'd0);
        @(negedge clk_i);
        mem_op_i = 4'd0;
        check_eq({tag, "_aerr"}, 32'(addr_err_o), 32'(op inside {[4'd1:4'd8]}));
        check_eq({tag, "_req"}, 32'(bus_req_o), 32'd0);
        @(negedge clk_i);
        check_eq({tag, "_aerr_low"}, 32'(addr_err_o), 32'd0);
        check_eq({tag, "_req2"}, 32'(bus_req_o), 32'd0);
    endtask

    initial begin
        rst_ni = 1'b0; mem_op_i = 4'd0; ao_i = 32'd0; wd_i = 32'd0;
        bus_ack_i = 1'b0; bus_rdata_i = 32'd0;
        repeat (2) @(negedge clk_i);
        check_eq("rst_req", 32'(bus_req_o), 32'd0);
        check_eq("rst_dr", dr_o, 32'd0);
        check_eq("rst_stall", 32'(stall_o), 32'd0);
        check_eq("rst_be", 32'(bus_be_o), 32'd0);
        check_eq("rst_aerr", 32'(addr_err_o), 32'd0);
        rst_ni = 1'b1;

        run_op("lw", 4'd1, 32'h0000_1004, 32'd0, 32'hDEAD_BEEF, 0);
        check_eq("lw_dr_const", dr_o, 32'hDEAD_BEEF);
        run_op("lb", 4'd4, 32'h0000_2003, 32'd0, 32'h80FF_FF7F, 0);
        check_eq("lb_dr_const", dr_o, 32'hFFFF_FF80);
        run_op("lbu", 4'd5, 32'h0000_2003, 32'd0, 32'h80FF_FF7F, 1);
        check_eq("lbu_dr_const", dr_o, 32'h0000_0080);
        run_op("lh", 4'd2, 32'h0000_3002, 32'd0, 32'h8001_0000, 0);
        check_eq("lh_dr_const", dr_o, 32'hFFFF_8001);
        run_op("lhu", 4'd3, 32'h0000_3000, 32'd0, 32'h1234_9ABC, 0);
        run_op("sb", 4'd8, 32'h0000_4002, 32'h1234_5678, 32'hFFFF_FFFF, 0);
        check_eq("sb_dr_kept", dr_o, 32'h0000_9ABC);
        run_op("sh", 4'd7, 32'h0000_4002, 32'h1234_5678, 32'hFFFF_FFFF, 2);
        run_op("sw", 4'd6, 32'h0000_5000, 32'hCAFE_F00D, 32'h0, 0);

        run_misaligned("lw_mis", 4'd1, 32'h0000_1002);
        run_misaligned("sh_mis", 4'd7, 32'h0000_1001);
        run_misaligned("op_none", 4'd12, 32'h0000_1001);

        // ack while IDLE must be ignored
        @(negedge clk_i);
        bus_ack_i = 1'b1; bus_rdata_i = 32'h5555_AAAA;
        @(negedge clk_i);
        bus_ack_i = 1'b0;
        check_eq("idle_ack_dr", dr_o, model_dr);
        check_eq("idle_ack_req", 32'(bus_req_o), 32'd0);
        run_op("lw_dly5", 4'd1, 32'h0000_6008, 32'd0, 32'h0BAD_F00D, 5);

        for (int k = 0; k < 6; k++) begin
            logic [3:0]  op;
            logic [31:0] ao;
            op = 4'($urandom_range(1, 8));
            ao = $urandom;
            if (op inside {4'd1, 4'd6}) ao[1:0] = 2'b00;
            if (op inside {4'd2, 4'd3, 4'd7}) ao[0] = 1'b0;
            run_op("rand", op, ao, $urandom, $urandom, int'($urandom_range(0, 3)));
        end

        // reset in the middle of BUSY
        @(negedge clk_i);
        mem_op_i = 4'd1; ao_i = 32'h0000_7000;
        @(negedge clk_i);
        mem_op_i = 4'd0;
        check_eq("mid_rst_busy", 32'(bus_req_o), 32'd1);
        rst_ni = 1'b0;
        @(negedge clk_i);
        check_eq("mid_rst_req", 32'(bus_req_o), 32'd0);
        check_eq("mid_rst_dr", dr_o, 32'd0);
        check_eq("mid_rst_stall", 32'(stall_o), 32'd0);
        check_eq("mid_rst_berr", 32'(bus_err_o), 32'd0);
        rst_ni = 1'b1;
        model_dr = 32'd0;

`ifdef DM_BUS_TIMEOUT_EN
        begin
            int busy_cnt;
            logic seen;
            run_op("pre_to", 4'd1, 32'h0000_8000, 32'd0, 32'h1111_2222, 0);
            @(negedge clk_i);
            mem_op_i = 4'd1; ao_i = 32'h0000_9000;
            @(negedge clk_i);
            mem_op_i = 4'd0;
            busy_cnt = 0;
            seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                if (bus_err_o) seen = 1'b1;
                else begin
                    if (bus_req_o) busy_cnt++;
                    @(negedge clk_i);
                end
            end
            check_eq("to_seen", 32'(seen), 32'd1);
            check_eq("to_busy_cycles", busy_cnt, TO);
            check_eq("to_dr", dr_o, 32'd0);
            check_eq("to_req", 32'(bus_req_o), 32'd0);
            @(negedge clk_i);
            check_eq("to_berr_pulse", 32'(bus_err_o), 32'd0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
